// File: rtl/stack_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// stack_ctrl
// ----------------------------------------------------------------------------
// Stack-operation sequencer for the stack-pointer / stack-RAM stage.
// It turns single-cycle push/pop requests into the multi-cycle control
// sequence that stage needs. It also tracks the stack depth and returns a
// one-cycle completion pulse.
//
// Push: IDLE -> WR -> STEP_DN -> IDLE      (ACK and SPC in STEP_DN)
// Pop : IDLE -> STEP_UP -> SETTLE -> RD -> IDLE   (SPC in STEP_UP, ACK in RD)
//
// Configuration macro: STACK_CTRL_GUARD_EN
//   defined   : a push at DEPTH_MAX or a pop at depth 0 is rejected via REJ.
//               The rejection sets the sticky OVF / UNF flag.
//   undefined : every request executes and DEPTH wraps modulo 256.
//               OVF / UNF are tied low, and CLR_ERR and DEPTH_MAX are unused.
//
// Parameters:
//   DEPTH_MAX  highest legal depth (1..255), used only with the guard
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   PUSH_REQ   push request, sampled in IDLE
//   POP_REQ    pop request, sampled in IDLE (loses to PUSH_REQ)
//   CLR_ERR    synchronous clear of OVF / UNF
//   nSK_EN     active-low stack bus transceiver enable
//   SP_D_nU    1 = down-count + RAM write, 0 = up-count + RAM read
//   SPC        one-cycle pointer step strobe
//   BUSY       high whenever the sequencer is not idle
//   ACK        one-cycle completion pulse (executed or rejected)
//   DEPTH      current stack depth
//   OVF / UNF  sticky overflow / underflow flags
// ============================================================================
module stack_ctrl #(
   parameter int DEPTH_MAX = 255
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PUSH_REQ,
   input  logic       POP_REQ,
   input  logic       CLR_ERR,
   output logic       nSK_EN,
   output logic       SP_D_nU,
   output logic       SPC,
   output logic       BUSY,
   output logic       ACK,
   output logic [7:0] DEPTH,
   output logic       OVF,
   output logic       UNF
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      STEP_DN,
      STEP_UP,
      SETTLE,
      RD
`ifdef STACK_CTRL_GUARD_EN
      , REJ
`endif
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       nsk_nxt;
   logic       dnu_nxt;
   logic       spc_nxt;
   logic       ack_nxt;
   logic [7:0] depth_nxt;

`ifdef STACK_CTRL_GUARD_EN
   localparam logic [7:0] DEPTH_LIMIT = 8'(DEPTH_MAX);
   logic set_ovf;
   logic set_unf;
`else
   logic unused_cfg;
   assign unused_cfg = ^{CLR_ERR, 8'(DEPTH_MAX)};
`endif

   // Next-state logic. A request is only looked at in IDLE, and push wins
   // over pop. With the guard, a request that would break the depth limits
   // goes to REJ and raises the matching error flag.
   always_comb begin
      next_state = state;
`ifdef STACK_CTRL_GUARD_EN
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (PUSH_REQ) begin
               next_state = WR;
`ifdef STACK_CTRL_GUARD_EN
               if (DEPTH == DEPTH_LIMIT) begin
                  next_state = REJ;
                  set_ovf    = 1'b1;
               end
`endif
            end else if (POP_REQ) begin
               next_state = STEP_UP;
`ifdef STACK_CTRL_GUARD_EN
               if (DEPTH == 8'd0) begin
                  next_state = REJ;
                  set_unf    = 1'b1;
               end
`endif
            end
         end
         WR:      next_state = STEP_DN;
         STEP_DN: next_state = IDLE;
         STEP_UP: next_state = SETTLE;
         SETTLE:  next_state = RD;
         RD:      next_state = IDLE;
`ifdef STACK_CTRL_GUARD_EN
         REJ:     next_state = IDLE;
`endif
         default: next_state = IDLE;
      endcase
   end

   // Output values are decoded from the state being entered, not the
   // current one. This lets every pin be a flop that changes together with
   // the state. SP_D_nU therefore can never glitch or move in the same cycle
   // as SPC. DEPTH is stepped on entry to the ACK state, so the requester
   // sees the new depth together with ACK.
   always_comb begin
      nsk_nxt   = 1'b1;
      dnu_nxt   = 1'b0;
      spc_nxt   = 1'b0;
      ack_nxt   = 1'b0;
      depth_nxt = DEPTH;
      case (next_state)
         WR: begin
            nsk_nxt = 1'b0;
            dnu_nxt = 1'b1;
         end
         STEP_DN: begin
            nsk_nxt   = 1'b0;
            dnu_nxt   = 1'b1;
            spc_nxt   = 1'b1;
            ack_nxt   = 1'b1;
            depth_nxt = DEPTH + 8'd1;
         end
         STEP_UP: begin
            spc_nxt = 1'b1;
         end
         SETTLE: begin
            nsk_nxt = 1'b0;
         end
         RD: begin
            nsk_nxt   = 1'b0;
            ack_nxt   = 1'b1;
            depth_nxt = DEPTH - 8'd1;
         end
`ifdef STACK_CTRL_GUARD_EN
         REJ: begin
            ack_nxt = 1'b1;
         end
`endif
         default: begin
            nsk_nxt = 1'b1;
         end
      endcase
   end

   // State register and registered outputs. Reset abandons any partial
   // operation without an ACK. The pointer stage shares this reset and
   // reloads its own start value, so DEPTH = 0 stays consistent with it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         nSK_EN  <= 1'b1;
         SP_D_nU <= 1'b0;
         SPC     <= 1'b0;
         ACK     <= 1'b0;
         BUSY    <= 1'b0;
         DEPTH   <= 8'd0;
      end else begin
         state   <= next_state;
         nSK_EN  <= nsk_nxt;
         SP_D_nU <= dnu_nxt;
         SPC     <= spc_nxt;
         ACK     <= ack_nxt;
         BUSY    <= (next_state != IDLE);
         DEPTH   <= depth_nxt;
      end
   end

`ifdef STACK_CTRL_GUARD_EN
   // Sticky error flags. A rejection setting a flag beats a simultaneous
   // CLR_ERR, so a rejection is never silently lost.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OVF <= 1'b0;
         UNF <= 1'b0;
      end else begin
         if (set_ovf)
            OVF <= 1'b1;
         else if (CLR_ERR)
            OVF <= 1'b0;
         if (set_unf)
            UNF <= 1'b1;
         else if (CLR_ERR)
            UNF <= 1'b0;
      end
   end
`else
   assign OVF = 1'b0;
   assign UNF = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_stack_ctrl
// ----------------------------------------------------------------------------
// Bench for stack_ctrl in whichever build (STACK_CTRL_GUARD_EN on or off).
// The reference model turns each accepted request into its list of expected
// output cycles and tracks depth and flags arithmetically. A small model of
// the pointer/RAM stage, driven by the DUT pins, checks LIFO data order.
// ============================================================================
module tb_stack_ctrl;

`ifdef STACK_CTRL_GUARD_EN
   localparam int DMAX  = 4;
   localparam bit GUARD = 1'b1;
`else
   localparam int DMAX  = 255;
   localparam bit GUARD = 1'b0;
`endif

   logic       CLK      = 1'b0;
   logic       RST      = 1'b0;
   logic       PUSH_REQ = 1'b0;
   logic       POP_REQ  = 1'b0;
   logic       CLR_ERR  = 1'b0;
   logic       nSK_EN;
   logic       SP_D_nU;
   logic       SPC;
   logic       BUSY;
   logic       ACK;
   logic [7:0] DEPTH;
   logic       OVF;
   logic       UNF;

   int errors = 0;
   int checks = 0;

   stack_ctrl #(.DEPTH_MAX(DMAX)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .PUSH_REQ (PUSH_REQ),
      .POP_REQ  (POP_REQ),
      .CLR_ERR  (CLR_ERR),
      .nSK_EN   (nSK_EN),
      .SP_D_nU  (SP_D_nU),
      .SPC      (SPC),
      .BUSY     (BUSY),
      .ACK      (ACK),
      .DEPTH    (DEPTH),
      .OVF      (OVF),
      .UNF      (UNF)
   );

   always #5 CLK = ~CLK;

   // One expected output cycle, plus its effect on depth and flags
   typedef struct {
      bit nsk;
      bit dnu;
      bit spc;
      bit ack;
      int dd;
      bit set_ovf;
      bit set_unf;
   } cyc_t;

   function automatic cyc_t mk(bit nsk, bit dnu, bit spc, bit ack,
                               int dd, bit so, bit su);
      cyc_t c;
      c.nsk = nsk; c.dnu = dnu; c.spc = spc; c.ack = ack;
      c.dd = dd; c.set_ovf = so; c.set_unf = su;
      return c;
   endfunction

   cyc_t       exp_q[$];
   cyc_t       cur = '{nsk: 1'b1, dnu: 1'b0, spc: 1'b0, ack: 1'b0, dd: 0, set_ovf: 1'b0, set_unf: 1'b0};
   bit         m_busy = 1'b0;
   int         m_depth = 0;
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;
   logic [7:0] golden[$];
   logic [7:0] exp_rd = 8'h00;
   bit         exp_rd_valid = 1'b0;
   logic [7:0] store_data = 8'h00;
   logic [7:0] ram[256];
   logic [7:0] ptr = 8'hFF;

   task automatic checkOutput(input string name, input logic [7:0] act,
                              input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: an accepted request expands into the cycle list the
   // sequence must produce; depth/flags follow from plain arithmetic.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         exp_q.delete();
         golden.delete();
         cur          = mk(1, 0, 0, 0, 0, 0, 0);
         m_busy       = 1'b0;
         m_depth      = 0;
         m_ovf        = 1'b0;
         m_unf        = 1'b0;
         exp_rd_valid = 1'b0;
         ptr          = 8'hFF;
      end else begin
         if (!m_busy) begin
            if (PUSH_REQ) begin
               if (GUARD && m_depth == DMAX)
                  exp_q.push_back(mk(1, 0, 0, 1, 0, 1, 0));
               else begin
                  exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
                  exp_q.push_back(mk(0, 1, 1, 1, 1, 0, 0));
                  golden.push_back(store_data);
                  if (golden.size() > 256)
                     void'(golden.pop_front());
               end
            end else if (POP_REQ) begin
               if (GUARD && m_depth == 0)
                  exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 1));
               else begin
                  exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
                  exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                  exp_q.push_back(mk(0, 0, 0, 1, -1, 0, 0));
                  exp_rd_valid = (golden.size() > 0);
                  if (exp_rd_valid)
                     exp_rd = golden.pop_back();
               end
            end
         end
         if (GUARD && CLR_ERR) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (exp_q.size() > 0) begin
            cur     = exp_q.pop_front();
            m_busy  = 1'b1;
            m_depth = (m_depth + cur.dd + 256) % 256;
            if (cur.set_ovf) m_ovf = 1'b1;
            if (cur.set_unf) m_unf = 1'b1;
         end else begin
            cur    = mk(1, 0, 0, 0, 0, 0, 0);
            m_busy = 1'b0;
         end
      end
   end

   // Requester data only changes while the model is idle
   always @(negedge CLK)
      if (!m_busy)
         store_data <= 8'($urandom);

   // Per-cycle comparison plus the pointer/RAM stage driven by DUT pins
   always @(negedge CLK) begin
      if (RST) begin
         checkOutput("nSK_EN", nSK_EN, cur.nsk);
         checkOutput("SP_D_nU", SP_D_nU, cur.dnu);
         checkOutput("SPC", SPC, cur.spc);
         checkOutput("ACK", ACK, cur.ack);
         checkOutput("BUSY", BUSY, m_busy);
         checkOutput("DEPTH", DEPTH, 8'(m_depth));
         checkOutput("OVF", OVF, m_ovf);
         checkOutput("UNF", UNF, m_unf);
         if (!nSK_EN && SP_D_nU)
            ram[ptr] = store_data;
         if (SPC)
            ptr = SP_D_nU ? ptr - 8'd1 : ptr + 8'd1;
         if (cur.ack && cur.dd == -1 && exp_rd_valid)
            checkOutput("lifo_data", ram[ptr], exp_rd);
      end
   end

   // Raise requests, wait (bounded) for ACK, then drop them
   task automatic applyStimulus(input bit push, input bit pop, input bit clr,
                                output int lat);
      @(negedge CLK); #1;
      PUSH_REQ = push;
      POP_REQ  = pop;
      CLR_ERR  = clr;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         if (ACK) begin
            lat = i;
            break;
         end
      end
      #1;
      PUSH_REQ = 1'b0;
      POP_REQ  = 1'b0;
      CLR_ERR  = 1'b0;
      if (lat < 0)
         checkOutput("ack_timeout", 8'd0, 8'd1);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   initial begin
      int lat;
      int acks;

      // Reset values, visible while reset is still held
      idleCycles(2);
      checkOutput("rst_nSK_EN", nSK_EN, 1'b1);
      checkOutput("rst_SP_D_nU", SP_D_nU, 1'b0);
      checkOutput("rst_BUSY", BUSY, 1'b0);
      checkOutput("rst_DEPTH", DEPTH, 8'd0);
      RST = 1'b1;
      idleCycles(2);

      // Single push: ACK on the second cycle after sampling, depth 1
      applyStimulus(1, 0, 0, lat);
      checkOutput("push_latency", 8'(lat), 8'd2);
      checkOutput("push_depth", DEPTH, 8'd1);

      // Two more pushes, then three pops in LIFO order
      applyStimulus(1, 0, 0, lat);
      applyStimulus(1, 0, 0, lat);
      checkOutput("depth3", DEPTH, 8'd3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, lat);
         checkOutput("pop_latency", 8'(lat), 8'd3);
      end
      checkOutput("depth0", DEPTH, 8'd0);

`ifdef STACK_CTRL_GUARD_EN
      // Underflow is rejected in one cycle, UNF set, then cleared
      applyStimulus(0, 1, 0, lat);
      checkOutput("unf_latency", 8'(lat), 8'd1);
      checkOutput("unf_flag", UNF, 1'b1);
      checkOutput("unf_depth", DEPTH, 8'd0);
      applyStimulus(0, 0, 1, lat);
      idleCycles(1);
      checkOutput("unf_clear", UNF, 1'b0);
      // Fifth push at DEPTH_MAX = 4 is rejected
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, lat);
      applyStimulus(1, 0, 0, lat);
      checkOutput("ovf_latency", 8'(lat), 8'd1);
      checkOutput("ovf_flag", OVF, 1'b1);
      checkOutput("ovf_depth", DEPTH, 8'd4);
`else
      // Pop at depth 0 executes and wraps to 255
      applyStimulus(0, 1, 0, lat);
      checkOutput("wrap_pop_latency", 8'(lat), 8'd3);
      checkOutput("wrap_pop_depth", DEPTH, 8'd255);
      applyStimulus(1, 0, 0, lat);
      checkOutput("wrap_push_depth", DEPTH, 8'd0);
      // 256 pushes wrap back to 0 and never flag overflow
      for (int i = 0; i < 256; i++) applyStimulus(1, 0, 0, lat);
      checkOutput("wrap256_depth", DEPTH, 8'd0);
      checkOutput("wrap256_ovf", OVF, 1'b0);
`endif

      // Restart from reset, push twice, then push+pop together
      RST = 1'b0;
      idleCycles(1);
      RST = 1'b1;
      applyStimulus(1, 0, 0, lat);
      applyStimulus(1, 0, 0, lat);
      applyStimulus(1, 1, 0, lat);
      checkOutput("simul_latency", 8'(lat), 8'd2);
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (ACK) acks++;
      end
      checkOutput("simul_extra_ack", 8'(acks), 8'd0);
      checkOutput("simul_depth", DEPTH, 8'd3);

      // Reset during SETTLE of a pop: immediate reset values, no ACK
      @(negedge CLK); #1;
      POP_REQ = 1'b1;
      @(negedge CLK);
      @(negedge CLK); #1;
      POP_REQ = 1'b0;
      RST     = 1'b0;
      #1;
      checkOutput("midrst_nSK_EN", nSK_EN, 1'b1);
      checkOutput("midrst_SPC", SPC, 1'b0);
      checkOutput("midrst_ACK", ACK, 1'b0);
      checkOutput("midrst_BUSY", BUSY, 1'b0);
      checkOutput("midrst_DEPTH", DEPTH, 8'd0);
      idleCycles(1);
      RST = 1'b1;
      idleCycles(2);
      checkOutput("midrst_depth_after", DEPTH, 8'd0);

      // A held push request runs back-to-back, three cycles per push
      @(negedge CLK); #1;
      PUSH_REQ = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (ACK) acks++;
      end
      #1;
      PUSH_REQ = 1'b0;
      checkOutput("held_push_acks", 8'(acks), 8'd2);
      idleCycles(2);
      checkOutput("held_push_depth", DEPTH, 8'd2);

      // Randomized traffic with occasional resets, checked every cycle
      for (int i = 0; i < 1500; i++) begin
         @(negedge CLK); #1;
         PUSH_REQ = ($urandom_range(0, 2) == 0);
         POP_REQ  = ($urandom_range(0, 2) == 0);
         CLR_ERR  = ($urandom_range(0, 7) == 0);
         RST      = ($urandom_range(0, 299) != 0);
      end
      @(negedge CLK); #1;
      PUSH_REQ = 1'b0;
      POP_REQ  = 1'b0;
      CLR_ERR  = 1'b0;
      RST      = 1'b1;
      idleCycles(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
